// File: rtl/rob_commit_reader_pkg.sv
// Shared widths, FSM states and exception codes for the ROB retire block.
package rob_commit_reader_pkg;

    localparam int ROB_BANKS   = 4;
    localparam int ROB_ROWS    = 32;
    localparam int PTR_W       = 6;
    localparam int ROW_W       = PTR_W - 1;
    localparam int IDX_W       = 8;
    localparam int RD_W        = 5;
    localparam int PD_W        = 8;
    localparam int EXC_W       = 8;
    localparam int XLEN        = 32;
    localparam int RECOVER_CYC = 4;
    localparam int CNT_W       = $clog2(RECOVER_CYC + 1);
    localparam int LANE_W      = $clog2(ROB_BANKS);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_RECOVER
    } state_t;

    localparam logic [EXC_W-1:0] EXC_INSN_MISALIGN = 8'h00;
    localparam logic [EXC_W-1:0] EXC_INSN_FAULT    = 8'h01;
    localparam logic [EXC_W-1:0] EXC_ILLEGAL_INSN  = 8'h02;
    localparam logic [EXC_W-1:0] EXC_BREAKPOINT    = 8'h03;
    localparam logic [EXC_W-1:0] EXC_ECALL_M       = 8'h0B;

    // Advance a row pointer; the top bit flips each time the row index wraps.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p[ROW_W-1:0] == ROW_W'(ROB_ROWS - 1))
            return {~p[PTR_W-1], {ROW_W{1'b0}}};
        else
            return p + PTR_W'(1);
    endfunction

endpackage

// File: rtl/rob_commit_reader_if.sv
// ROB read/clear port plus the commit, free-list and redirect outputs.
interface rob_commit_reader_if;
    import rob_commit_reader_pkg::*;

    logic [PTR_W-1:0]                     tail_ptr;
    logic [XLEN-1:0]                      mtvec;

    logic                                 rob_ren;
    logic [IDX_W-1:0]                     rob_rindex;
    logic [ROB_BANKS-1:0]                 rob_valid;
    logic [ROB_BANKS-1:0]                 rob_rdy;
    logic [ROB_BANKS-1:0]                 rob_hasrd;
    logic [ROB_BANKS-1:0][RD_W-1:0]       rob_rd;
    logic [ROB_BANKS-1:0][PD_W-1:0]       rob_pd;
    logic [ROB_BANKS-1:0][PD_W-1:0]       rob_oldpd;
    logic [ROB_BANKS-1:0]                 rob_isstore;
    logic [ROB_BANKS-1:0]                 rob_isbranch;
    logic [ROB_BANKS-1:0]                 rob_branch_res;
    logic [ROB_BANKS-1:0][XLEN-1:0]       rob_target;
    logic [ROB_BANKS-1:0][XLEN-1:0]       rob_pred_addr;
    logic [ROB_BANKS-1:0][XLEN-1:0]       rob_pc;
    logic [ROB_BANKS-1:0]                 rob_hasexc;
    logic [ROB_BANKS-1:0][EXC_W-1:0]      rob_exctype;

    logic [ROB_BANKS-1:0]                 clr_wen;
    logic [IDX_W-1:0]                     clr_index;
    logic [ROB_BANKS-1:0]                 commit_mask;
    logic [ROB_BANKS-1:0][RD_W-1:0]       commit_rd;
    logic [ROB_BANKS-1:0][PD_W-1:0]       commit_pd;
    logic [ROB_BANKS-1:0]                 free_oldpd_v;
    logic [ROB_BANKS-1:0][PD_W-1:0]       free_oldpd;
    logic [ROB_BANKS-1:0]                 store_commit;
    logic [PTR_W-1:0]                     head_ptr;
    logic                                 flush;
    logic [XLEN-1:0]                      redirect_pc;
    logic                                 exc_valid;
    logic [EXC_W-1:0]                     exc_type;
    logic                                 flush_busy;

    modport master (
        input  tail_ptr, mtvec,
               rob_valid, rob_rdy, rob_hasrd, rob_rd, rob_pd, rob_oldpd,
               rob_isstore, rob_isbranch, rob_branch_res, rob_target,
               rob_pred_addr, rob_pc, rob_hasexc, rob_exctype,
        output rob_ren, rob_rindex, clr_wen, clr_index, commit_mask,
               commit_rd, commit_pd, free_oldpd_v, free_oldpd, store_commit,
               head_ptr, flush, redirect_pc, exc_valid, exc_type, flush_busy
    );

    modport slave (
        output tail_ptr, mtvec,
               rob_valid, rob_rdy, rob_hasrd, rob_rd, rob_pd, rob_oldpd,
               rob_isstore, rob_isbranch, rob_branch_res, rob_target,
               rob_pred_addr, rob_pc, rob_hasexc, rob_exctype,
        input  rob_ren, rob_rindex, clr_wen, clr_index, commit_mask,
               commit_rd, commit_pd, free_oldpd_v, free_oldpd, store_commit,
               head_ptr, flush, redirect_pc, exc_valid, exc_type, flush_busy
    );
endinterface

// File: rtl/rob_commit_reader_lane_sel.sv
// Combinational evaluation of one ROB row: readiness, first stopping lane,
// and which lanes would retire if the row is taken this cycle.
module rob_commit_lane_sel
    import rob_commit_reader_pkg::*;
#(
    parameter int BANKS = ROB_BANKS,
    parameter int LW    = LANE_W
) (
    input  logic [BANKS-1:0]            valid,
    input  logic [BANKS-1:0]            rdy,
    input  logic [BANKS-1:0]            hasexc,
    input  logic [BANKS-1:0]            isbranch,
    input  logic [BANKS-1:0]            branch_res,
    input  logic [BANKS-1:0][XLEN-1:0]  target,
    input  logic [BANKS-1:0][XLEN-1:0]  pred_addr,
    input  logic [BANKS-1:0][XLEN-1:0]  pc,
    output logic                        row_ready,
    output logic                        stop_found,
    output logic [LW-1:0]               stop_lane,
    output logic                        stop_is_exc,
    output logic [BANKS-1:0]            commit_mask,
    output logic [BANKS-1:0][XLEN-1:0]  actual_next
);

    logic [BANKS-1:0] stop_req;

    // Per-lane resolved next PC and stop request (exception or mispredict).
    for (genvar g = 0; g < BANKS; g++) begin : g_lane
        assign actual_next[g] = branch_res[g] ? target[g] : pc[g] + XLEN'(4);
        assign stop_req[g]    = valid[g] &
                                (hasexc[g] | (isbranch[g] & (actual_next[g] != pred_addr[g])));
    end

    // A row is ready once every occupied lane has its result.
    assign row_ready = &(rdy | ~valid);

    // Lowest stopping lane wins; an exception lane itself does not retire.
    always_comb begin
        stop_found  = 1'b0;
        stop_lane   = '0;
        stop_is_exc = 1'b0;
        commit_mask = '0;
        for (int i = BANKS - 1; i >= 0; i--) begin
            if (stop_req[i]) begin
                stop_found  = 1'b1;
                stop_lane   = LW'(i);
                stop_is_exc = hasexc[i];
            end
        end
        for (int i = 0; i < BANKS; i++) begin
            if (!stop_found || (LW'(i) < stop_lane) ||
                ((LW'(i) == stop_lane) && !stop_is_exc))
                commit_mask[i] = valid[i];
        end
    end

endmodule

// File: rtl/rob_commit_reader.sv
// In-order ROB retire: reads the head row, retires ready lanes in bank order,
// clears their valid bits and raises flush/redirect on exception or mispredict.
module rob_commit_reader
    import rob_commit_reader_pkg::*;
#(
    parameter int RECOVER_CYC_P = RECOVER_CYC
) (
    input  logic                 clk,
    input  logic                 rst,
    rob_commit_reader_if.master  bus
);

    state_t                      state_q, state_d;
    logic [PTR_W-1:0]            head_q, head_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;

    logic                        empty;
    logic                        row_ready;
    logic                        stop_found;
    logic [LANE_W-1:0]           stop_lane;
    logic                        stop_is_exc;
    logic [ROB_BANKS-1:0]        sel_mask;
    logic [ROB_BANKS-1:0][XLEN-1:0] actual_next;

    logic                        ren;
    logic [ROB_BANKS-1:0]        commit;
    logic                        flush_o;
    logic                        exc_o;
    logic [EXC_W-1:0]            exc_type_o;
    logic [XLEN-1:0]             redirect_o;
    logic                        busy;
    logic [IDX_W-1:0]            row_idx;

    assign empty   = (head_q == bus.tail_ptr);
    assign row_idx = {{(IDX_W-ROW_W){1'b0}}, head_q[ROW_W-1:0]};

    rob_commit_lane_sel #(.BANKS(ROB_BANKS), .LW(LANE_W)) u_sel (
        .valid       (bus.rob_valid),
        .rdy         (bus.rob_rdy),
        .hasexc      (bus.rob_hasexc),
        .isbranch    (bus.rob_isbranch),
        .branch_res  (bus.rob_branch_res),
        .target      (bus.rob_target),
        .pred_addr   (bus.rob_pred_addr),
        .pc          (bus.rob_pc),
        .row_ready   (row_ready),
        .stop_found  (stop_found),
        .stop_lane   (stop_lane),
        .stop_is_exc (stop_is_exc),
        .commit_mask (sel_mask),
        .actual_next (actual_next)
    );

    // State, head pointer and recovery counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            head_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and retire outputs; a flush row holds head until FLUSH zeroes it.
    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        cnt_d      = cnt_q;
        ren        = 1'b0;
        commit     = '0;
        flush_o    = 1'b0;
        exc_o      = 1'b0;
        exc_type_o = '0;
        redirect_o = '0;
        busy       = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                ren = !empty;
                if (!empty && row_ready) begin
                    commit = sel_mask;
                    if (stop_found) begin
                        flush_o = 1'b1;
                        state_d = ST_FLUSH;
                        if (stop_is_exc) begin
                            exc_o      = 1'b1;
                            exc_type_o = bus.rob_exctype[stop_lane];
                            redirect_o = bus.mtvec;
                        end else begin
                            redirect_o = actual_next[stop_lane];
                        end
                    end else begin
                        head_d = ptr_inc(head_q);
                    end
                end
            end
            ST_FLUSH: begin
                busy    = 1'b1;
                head_d  = '0;
                cnt_d   = CNT_W'(RECOVER_CYC_P - 1);
                state_d = ST_RECOVER;
            end
            ST_RECOVER: begin
                busy = 1'b1;
                if (cnt_q == '0)
                    state_d = ST_RUN;
                else
                    cnt_d = cnt_q - CNT_W'(1);
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign bus.rob_ren      = ren;
    assign bus.rob_rindex   = row_idx;
    assign bus.clr_index    = row_idx;
    assign bus.clr_wen      = commit;
    assign bus.commit_mask  = commit;
    assign bus.free_oldpd_v = commit & bus.rob_hasrd;
    assign bus.store_commit = commit & bus.rob_isstore;
    assign bus.head_ptr     = head_q;
    assign bus.flush        = flush_o;
    assign bus.redirect_pc  = redirect_o;
    assign bus.exc_valid    = exc_o;
    assign bus.exc_type     = exc_type_o;
    assign bus.flush_busy   = busy;

    // Per-lane commit data is zeroed on lanes that are not retiring.
    for (genvar g = 0; g < ROB_BANKS; g++) begin : g_out
        assign bus.commit_rd[g]  = commit[g] ? bus.rob_rd[g] : '0;
        assign bus.commit_pd[g]  = commit[g] ? bus.rob_pd[g] : '0;
        assign bus.free_oldpd[g] = (commit[g] & bus.rob_hasrd[g]) ? bus.rob_oldpd[g] : '0;
    end

endmodule

// File: tb/tb_rob_commit_reader.sv
// Bench: ROB storage model behind the read port, a row-level reference model
// feeding a scoreboard, and a monitor comparing every retire/flush cycle.
module tb_rob_commit_reader;
    import rob_commit_reader_pkg::*;

    typedef struct {
        logic        valid, rdy, hasrd, isstore, isbranch, br_res, hasexc;
        logic [4:0]  rd;
        logic [7:0]  pd, oldpd, exctype;
        logic [31:0] target, pred, pc;
    } lane_t;

    typedef struct {
        logic [ROB_BANKS-1:0]           mask, clr, free_v, store;
        logic                           flush, exc_valid;
        logic [7:0]                     exc_type, clr_index;
        logic [31:0]                    redirect;
        logic [ROB_BANKS-1:0][RD_W-1:0] rd;
        logic [ROB_BANKS-1:0][PD_W-1:0] pd, oldpd;
    } ev_t;

    localparam logic [31:0] MTVEC = 32'h80000800;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    lane_t mem [ROB_ROWS][ROB_BANKS];
    ev_t   sbq [$];
    logic [PTR_W-1:0] mhead = '0;

    rob_commit_reader_if bus();
    rob_commit_reader dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Storage read port: combinational data for the addressed row.
    always_comb begin
        for (int b = 0; b < ROB_BANKS; b++) begin
            bus.rob_valid[b]      = mem[bus.rob_rindex[ROW_W-1:0]][b].valid;
            bus.rob_rdy[b]        = mem[bus.rob_rindex[ROW_W-1:0]][b].rdy;
            bus.rob_hasrd[b]      = mem[bus.rob_rindex[ROW_W-1:0]][b].hasrd;
            bus.rob_isstore[b]    = mem[bus.rob_rindex[ROW_W-1:0]][b].isstore;
            bus.rob_isbranch[b]   = mem[bus.rob_rindex[ROW_W-1:0]][b].isbranch;
            bus.rob_branch_res[b] = mem[bus.rob_rindex[ROW_W-1:0]][b].br_res;
            bus.rob_hasexc[b]     = mem[bus.rob_rindex[ROW_W-1:0]][b].hasexc;
            bus.rob_rd[b]         = mem[bus.rob_rindex[ROW_W-1:0]][b].rd;
            bus.rob_pd[b]         = mem[bus.rob_rindex[ROW_W-1:0]][b].pd;
            bus.rob_oldpd[b]      = mem[bus.rob_rindex[ROW_W-1:0]][b].oldpd;
            bus.rob_exctype[b]    = mem[bus.rob_rindex[ROW_W-1:0]][b].exctype;
            bus.rob_target[b]     = mem[bus.rob_rindex[ROW_W-1:0]][b].target;
            bus.rob_pred_addr[b]  = mem[bus.rob_rindex[ROW_W-1:0]][b].pred;
            bus.rob_pc[b]         = mem[bus.rob_rindex[ROW_W-1:0]][b].pc;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Reference: retire rule for one row, lane by lane in bank order.
    task automatic model_row(input int r, output ev_t e, output bit has_ev, output bit stop);
        lane_t l;
        logic [31:0] actual;
        e = '{default: '0};
        has_ev = 0;
        stop = 0;
        for (int b = 0; b < ROB_BANKS; b++)
            if (mem[r][b].valid && !mem[r][b].rdy) return;
        e.clr_index = 8'(r);
        for (int b = 0; b < ROB_BANKS; b++) begin
            l = mem[r][b];
            if (!l.valid) continue;
            actual = l.br_res ? l.target : l.pc + 32'd4;
            if (l.hasexc) begin
                e.flush = 1; e.exc_valid = 1; e.exc_type = l.exctype; e.redirect = MTVEC;
                break;
            end
            e.mask[b] = 1'b1;
            e.rd[b] = l.rd;
            e.pd[b] = l.pd;
            if (l.hasrd) begin e.free_v[b] = 1'b1; e.oldpd[b] = l.oldpd; end
            if (l.isstore) e.store[b] = 1'b1;
            if (l.isbranch && actual != l.pred) begin
                e.flush = 1; e.redirect = actual;
                break;
            end
        end
        e.clr  = e.mask;
        has_ev = (e.mask != '0) || e.flush;
        stop   = e.flush;
    endtask

    // Monitor: every cycle that retires or flushes must match the next expected event.
    ev_t mev;
    logic [ROB_BANKS-1:0][RD_W-1:0] a_rd;
    logic [ROB_BANKS-1:0][PD_W-1:0] a_pd, a_old;
    always @(negedge clk) begin
        if (!rst && (bus.commit_mask != '0 || bus.flush)) begin
            if (sbq.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_retire actual mask=%0h flush=%0b required none @%0t",
                         bus.commit_mask, bus.flush, $time);
            end else begin
                mev = sbq.pop_front();
                a_rd = '0; a_pd = '0; a_old = '0;
                for (int b = 0; b < ROB_BANKS; b++) begin
                    if (mev.mask[b])   begin a_rd[b] = bus.commit_rd[b]; a_pd[b] = bus.commit_pd[b]; end
                    if (mev.free_v[b]) a_old[b] = bus.free_oldpd[b];
                end
                chk("commit_mask",  64'(bus.commit_mask),  64'(mev.mask));
                chk("clr_wen",      64'(bus.clr_wen),      64'(mev.clr));
                chk("clr_index",    64'(bus.clr_index),    64'(mev.clr_index));
                chk("free_oldpd_v", 64'(bus.free_oldpd_v), 64'(mev.free_v));
                chk("store_commit", 64'(bus.store_commit), 64'(mev.store));
                chk("flush",        64'(bus.flush),        64'(mev.flush));
                chk("redirect_pc",  64'(bus.redirect_pc),  64'(mev.redirect));
                chk("exc_valid",    64'(bus.exc_valid),    64'(mev.exc_valid));
                chk("exc_type",     64'(bus.exc_type),     64'(mev.exc_type));
                chk("commit_rd",    64'(a_rd),             64'(mev.rd));
                chk("commit_pd",    64'(a_pd),             64'(mev.pd));
                chk("free_oldpd",   64'(a_old),            64'(mev.oldpd));
            end
        end
    end

    task automatic clear_mem();
        for (int r = 0; r < ROB_ROWS; r++)
            for (int b = 0; b < ROB_BANKS; b++)
                mem[r][b] = '{default: '0};
    endtask

    task automatic plain_lane(input int r, input int b, input bit v);
        mem[r][b] = '{default: '0};
        mem[r][b].valid   = v;
        mem[r][b].rdy     = 1'b1;
        mem[r][b].hasrd   = 1'(($urandom % 4) != 0);
        mem[r][b].isstore = 1'($urandom % 2);
        mem[r][b].rd      = 5'($urandom);
        mem[r][b].pd      = 8'($urandom);
        mem[r][b].oldpd   = 8'($urandom);
        mem[r][b].pc      = $urandom & 32'hFFFF_FFFC;
    endtask

    task automatic rand_row(input int r);
        bit any = 0;
        logic [31:0] act;
        for (int b = 0; b < ROB_BANKS; b++) begin
            plain_lane(r, b, ($urandom_range(0, 4) != 0));
            any |= mem[r][b].valid;
            if ($urandom_range(0, 3) == 0) begin
                mem[r][b].isbranch = 1'b1;
                mem[r][b].isstore  = 1'b0;
                mem[r][b].br_res   = 1'($urandom % 2);
                mem[r][b].target   = $urandom & 32'hFFFF_FFFC;
                act = mem[r][b].br_res ? mem[r][b].target : mem[r][b].pc + 32'd4;
                mem[r][b].pred = ($urandom_range(0, 2) == 0) ? ($urandom & 32'hFFFF_FFFC) : act;
            end
            if ($urandom_range(0, 15) == 0) begin
                mem[r][b].hasexc  = 1'b1;
                mem[r][b].exctype = 8'($urandom_range(0, 15));
            end
        end
        if (!any) mem[r][0].valid = 1'b1;
    endtask

    // Wait for the DUT to drain the queued rows or to flush, then check the outcome.
    task automatic wait_done(input bit exf, input logic [PTR_W-1:0] eh);
        bit seen = 0;
        int n = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (bus.flush) begin seen = 1; break; end
            if (!exf && bus.head_ptr == bus.tail_ptr) break;
        end
        if (exf) begin
            chk("flush_seen", 64'(seen), 64'(1));
            @(posedge clk); #1;
            bus.tail_ptr = '0;
            clear_mem();
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (!bus.flush_busy) break;
                n++;
            end
            chk("flush_busy_cycles", 64'(n), 64'(1 + RECOVER_CYC));
        end
        chk("head_ptr", 64'(bus.head_ptr), 64'(eh));
        chk("scoreboard_drained", 64'(sbq.size()), 64'(0));
        mhead = eh;
    endtask

    task automatic run_rows(input int k);
        ev_t e;
        bit has, stop, exf = 0;
        logic [PTR_W-1:0] p = mhead, eh;
        for (int i = 0; i < k; i++) begin
            if (!exf) begin
                model_row(int'(p[ROW_W-1:0]), e, has, stop);
                if (has) sbq.push_back(e);
                if (stop) exf = 1;
            end
            p = p + PTR_W'(1);
        end
        eh = exf ? '0 : p;
        @(posedge clk); #1;
        bus.tail_ptr = p;
        wait_done(exf, eh);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.tail_ptr = '0;
        clear_mem();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mhead = '0;
        @(negedge clk);
    endtask

    initial begin
        ev_t e;
        bit has, stop, seen, anybusy;
        bus.mtvec = MTVEC;
        do_reset();
        chk("rst_rob_ren",     64'(bus.rob_ren),     64'(0));
        chk("rst_commit_mask", 64'(bus.commit_mask), 64'(0));
        chk("rst_clr_wen",     64'(bus.clr_wen),     64'(0));
        chk("rst_flush",       64'(bus.flush),       64'(0));
        chk("rst_flush_busy",  64'(bus.flush_busy),  64'(0));
        chk("rst_head_ptr",    64'(bus.head_ptr),    64'(0));

        // Full row 0, every lane writes rd.
        for (int b = 0; b < ROB_BANKS; b++) begin plain_lane(0, b, 1); mem[0][b].hasrd = 1'b1; end
        run_rows(1);
        chk("empty_rob_ren", 64'(bus.rob_ren), 64'(0));

        // Row 1: lane 3 valid but not ready -> whole row stalls.
        for (int b = 0; b < ROB_BANKS; b++) plain_lane(1, b, b != 2);
        mem[1][3].rdy = 1'b0;
        @(posedge clk); #1 bus.tail_ptr = 6'd2;
        repeat (3) @(negedge clk);
        chk("stall_commit_mask", 64'(bus.commit_mask), 64'(0));
        chk("stall_clr_wen",     64'(bus.clr_wen),     64'(0));
        chk("stall_rob_ren",     64'(bus.rob_ren),     64'(1));
        chk("stall_head_ptr",    64'(bus.head_ptr),    64'(1));
        @(posedge clk); #1 mem[1][3].rdy = 1'b1;
        model_row(1, e, has, stop);
        if (has) sbq.push_back(e);
        wait_done(0, 6'd2);

        // Row 2: taken branch mispredicted in lane 1.
        for (int b = 0; b < ROB_BANKS; b++) plain_lane(2, b, 1);
        mem[2][1].pc = 32'h80000010; mem[2][1].isbranch = 1'b1; mem[2][1].br_res = 1'b1;
        mem[2][1].target = 32'h80000100; mem[2][1].pred = 32'h80000014;
        run_rows(1);

        // Row 0 after flush: exception in lane 2.
        for (int b = 0; b < ROB_BANKS; b++) plain_lane(0, b, 1);
        mem[0][2].hasexc = 1'b1; mem[0][2].exctype = EXC_ILLEGAL_INSN;
        run_rows(1);

        // Randomized rows.
        repeat (40) begin
            int k = $urandom_range(1, 6);
            for (int i = 0; i < k; i++) rand_row(int'(mhead[ROW_W-1:0]) + i < ROB_ROWS ?
                                                  int'(mhead[ROW_W-1:0]) + i :
                                                  int'(mhead[ROW_W-1:0]) + i - ROB_ROWS);
            run_rows(k);
        end

        // Full ROB from head 0: head wraps to 0b100000 and the ROB reads empty.
        do_reset();
        for (int r = 0; r < ROB_ROWS; r++)
            for (int b = 0; b < ROB_BANKS; b++) plain_lane(r, b, (b == 0) || ($urandom % 2 == 1));
        run_rows(ROB_ROWS);
        chk("wrap_rob_ren", 64'(bus.rob_ren), 64'(0));

        // Reset while recovering: no flush replay afterwards.
        for (int b = 0; b < ROB_BANKS; b++) plain_lane(0, b, 1);
        mem[0][0].hasexc = 1'b1; mem[0][0].exctype = EXC_ECALL_M;
        model_row(0, e, has, stop);
        sbq.push_back(e);
        @(posedge clk); #1 bus.tail_ptr = 6'd33;
        seen = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.flush) begin seen = 1; break; end
        end
        chk("rr_flush_seen", 64'(seen), 64'(1));
        @(posedge clk); #1 bus.tail_ptr = '0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("rr_in_recover_busy", 64'(bus.flush_busy), 64'(1));
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rr_flush_busy", 64'(bus.flush_busy), 64'(0));
        chk("rr_rob_ren",    64'(bus.rob_ren),    64'(0));
        chk("rr_head_ptr",   64'(bus.head_ptr),   64'(0));
        anybusy = 0;
        repeat (8) begin
            @(negedge clk);
            anybusy |= bus.flush_busy | bus.flush;
        end
        chk("rr_no_replay", 64'(anybusy), 64'(0));
        chk("rr_drained",   64'(sbq.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
